// File: rtl/pc_sequencer_if.sv
// Bundles the control inputs and architectural outputs of the PC sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; the stall line inside the bundle is the only hold mechanism.
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             halt;
  logic             jump;
  logic             branch;
  logic             bne;
  logic             zero;
  logic [15:0]      imm16;
  logic [25:0]      jtarget;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             halted;
  logic [CNT_W-1:0] retired;

  // Decode/test side: drives control, observes PC state
  modport master (
    output stall, halt, jump, branch, bne, zero, imm16, jtarget,
    input  pc, pc_plus4, halted, retired
  );

  // Sequencer side: consumes control, owns PC state
  modport slave (
    input  stall, halt, jump, branch, bne, zero, imm16, jtarget,
    output pc, pc_plus4, halted, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds PC, selects next PC, detects halt, counts retirement.
// Latency: next PC visible one rising edge after inputs are sampled; pc_plus4 is combinational.
// Backpressure: stall freezes all state for the cycle; HALT absorbs until reset.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0020,
  parameter int          CNT_W        = 32
) (
  input  logic          clk,
  input  logic          nreset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      pc_q;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;

  logic [31:0]      pc_plus4;
  logic [31:0]      imm_off;
  logic [31:0]      br_target;
  logic [31:0]      jmp_target;
  logic             taken;
  logic [31:0]      next_pc;

  // Sequential successor; wraps naturally modulo 2^32
  assign pc_plus4 = pc_q + 32'd4;

  // Word offset sign-extended and scaled to bytes
  assign imm_off    = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign br_target  = pc_plus4 + imm_off;
  assign jmp_target = {pc_plus4[31:28], bus.jtarget, 2'b00};

  // bne selects which zero-flag sense makes the branch taken
  assign taken = bus.branch & (bus.zero ^ bus.bne);

  // Next-PC select: jump outranks branch; an untaken branch is plain sequential
  always_comb begin
    next_pc = pc_plus4;
    if (bus.jump) begin
      next_pc = jmp_target;
    end else if (taken) begin
      next_pc = br_target;
    end
  end

  // Sequencer FSM: one BOOT edge after reset, then RUN until a halt is accepted
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= BOOT;
      pc_q      <= RESET_VECTOR;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (!bus.stall) begin
            retired_q <= retired_q + CNT_W'(1);
            if (bus.halt) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= next_pc;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.halted   = halted_q;
  assign bus.retired  = retired_q;

  // PC must stay word aligned at all times
  a_pc_aligned : assert property (@(posedge clk) disable iff (!nreset) pc_q[1:0] == 2'b00);

  // halted and the HALT state must always agree
  a_halt_state : assert property (@(posedge clk) disable iff (!nreset) halted_q == (state == HALT));

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed plan followed by randomized control.
// Stimulus pushes model predictions at the falling edge; a monitor pops at rising edge + 1.
// Async reset checks are pushed mid-cycle and popped through an event, with no clock edge.
module tb_pc_sequencer;

  localparam logic [31:0] RV    = 32'h0040_0020;
  localparam int          CNT_W = 32;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] retired;
  } exp_t;

  logic clk;
  logic nreset;
  pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pc_sequencer #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  expq[$];
  event  async_ev;
  int    n_cmp;
  int    n_bad;

  // Reference model state: "booting" means the next edge is the boot edge
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] m_retired;
  bit          m_booting;

  task automatic model_reset();
    m_pc      = RV;
    m_halted  = 1'b0;
    m_retired = 0;
    m_booting = 1'b1;
  endtask

  // Architectural effect of one rising edge given the inputs presented
  task automatic model_edge(input logic st, h, j, b, bn, z,
                            input logic [15:0] im, input logic [25:0] jt);
    int off;
    if (!nreset) begin
      model_reset();
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_halted || st) begin
      // nothing moves
    end else if (h) begin
      m_halted  = 1'b1;
      m_retired = m_retired + 1;
    end else begin
      m_retired = m_retired + 1;
      if (j) begin
        m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jt) << 2);
      end else if (b && (z != bn)) begin
        off  = int'($signed(im)) * 4;
        m_pc = m_pc + 32'd4 + 32'(off);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  function automatic exp_t snap(input string tag);
    exp_t e;
    e.tag     = tag;
    e.pc      = m_pc;
    e.halted  = m_halted;
    e.retired = m_retired;
    return e;
  endfunction

  // One clock: drive at falling edge, predict the following rising edge
  task automatic cyc(input string tag, input logic nr, st, h, j, b, bn, z,
                     input logic [15:0] im, input logic [25:0] jt);
    @(negedge clk);
    nreset      = nr;
    bus.stall   = st;
    bus.halt    = h;
    bus.jump    = j;
    bus.branch  = b;
    bus.bne     = bn;
    bus.zero    = z;
    bus.imm16   = im;
    bus.jtarget = jt;
    model_edge(st, h, j, b, bn, z, im, jt);
    expq.push_back(snap(tag));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
  endtask

  task automatic jmp(input string tag, input logic [25:0] jt);
    cyc(tag, 1'b1, 0, 0, 1, 0, 0, 0, 16'h0, jt);
  endtask

  // Pull reset low between edges and check outputs before any edge occurs
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    model_reset();
    expq.push_back(snap(tag));
    -> async_ev;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: compare every presented output against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk({e.tag, ".pc"},       bus.pc,              e.pc);
        chk({e.tag, ".pc_plus4"}, bus.pc_plus4,        e.pc + 32'd4);
        chk({e.tag, ".halted"},   32'(bus.halted),     32'(e.halted));
        chk({e.tag, ".retired"},  32'(bus.retired),    e.retired);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic st, h, j, b, bn, z;
    logic [15:0] im;
    logic [25:0] jt;
    int wait_cnt;
    n_cmp = 0;
    n_bad = 0;
    nreset = 1'b0;
    bus.stall = 0; bus.halt = 0; bus.jump = 0; bus.branch = 0;
    bus.bne = 0; bus.zero = 0; bus.imm16 = '0; bus.jtarget = '0;
    model_reset();

    // Reset held, then free run: boot edge holds pc, then +4 per edge
    cyc("rst", 1'b0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    cyc("rst", 1'b0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    cyc("boot", 1'b1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    idle("seq", 2);
    idle("seq2", 2);
    // Branch cases from pc=0x00400030
    cyc("br_beq_taken", 1'b1, 0, 0, 0, 1, 0, 1, 16'hFFFC, 26'h0);
    jmp("jmp_to_30", 26'h010000C);
    cyc("br_beq_not", 1'b1, 0, 0, 0, 1, 0, 0, 16'hFFFC, 26'h0);
    jmp("jmp_to_30b", 26'h010000C);
    cyc("br_bne_taken", 1'b1, 0, 0, 0, 1, 1, 0, 16'h0003, 26'h0);
    // Jumps from pc=0x00400040
    jmp("jmp_to_20", 26'h0100008);
    jmp("jmp_to_40", 26'h0100010);
    cyc("jmp_over_br", 1'b1, 0, 0, 1, 1, 0, 1, 16'h0010, 26'h0100008);
    // Wrap: jump low, branch backwards past zero, then step across
    jmp("jmp_low", 26'h0000004);
    cyc("br_wrap", 1'b1, 0, 0, 0, 1, 0, 1, 16'hFFFA, 26'h0);
    idle("seq_wrap", 2);
    async_reset("async_rst_run");
    cyc("rst_hold", 1'b0, 0, 0, 1, 0, 0, 0, 16'h0, 26'h5);
    cyc("boot2", 1'b1, 0, 1, 1, 1, 0, 1, 16'h7, 26'h5);
    idle("seq3", 1);
    // Stall overrides halt, then halt accepted, then everything ignored
    for (int i = 0; i < 4; i++) cyc("stall_halt", 1'b1, 1, 1, 0, 0, 0, 0, 16'h0, 26'h0);
    cyc("halt", 1'b1, 0, 1, 0, 0, 0, 0, 16'h0, 26'h0);
    cyc("halted_jmp", 1'b1, 0, 0, 1, 0, 0, 0, 16'h0, 26'h0100010);
    cyc("halted_br", 1'b1, 0, 0, 0, 1, 0, 1, 16'h0040, 26'h0);
    async_reset("async_rst_halt");
    cyc("rst_hold2", 1'b0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0);

    // Randomized control with periodic async resets
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) begin
        async_reset("rnd_async_rst");
        cyc("rnd_rst_hold", 1'b0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
      end
      st = ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 47) == 0);
      j  = ($urandom_range(0, 5) == 0);
      b  = ($urandom_range(0, 2) == 0);
      bn = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      im = 16'($urandom);
      jt = 26'($urandom);
      cyc("rnd", 1'b1, st, h, j, b, bn, z, im, jt);
    end
    idle("tail", 2);

    // Drain: every prediction must have been consumed
    wait_cnt = 0;
    while (expq.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    chk("drain_queue_left", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle processor datapath. It holds the architectural PC and computes the next PC from sequential, branch and jump inputs. It also implements the halt condition: the decode stage's OR-reduced halt-match line feeds this block directly. It drives the instruction-memory address and a retired-instruction count used by the testbench.

## Interface
- RESET_VECTOR, 32'h0040_0020, PC value loaded on reset; bits [1:0] must be 0
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising-edge active
- nreset  in  1  asynchronous, active-low reset
- stall  in  1  hold all state this cycle (memory not ready)
- halt  in  1  current instruction is a halt (OR-reduced opcode match from decode)
- jump  in  1  current instruction is an unconditional jump
- branch  in  1  current instruction is a conditional branch
- bne  in  1  branch sense: 0 = taken on zero, 1 = taken on not-zero
- zero  in  1  ALU zero flag for current instruction
- imm16  in  16  branch offset in words, two's complement
- jtarget  in  26  jump target field, word address
- pc  out  32  current PC (instruction-memory address), registered
- pc_plus4  out  32  pc + 4, combinational from pc
- halted  out  1  processor halted, registered, sticky
- retired  out  CNT_W  count of retired instructions, registered

## Operation
- State machine: BOOT, RUN, HALT.
- Reset (nreset low, asynchronous):
  - state = BOOT, pc = RESET_VECTOR, halted = 0, retired = 0.
- BOOT:
  - Lasts exactly one clock edge after reset deassertion.
  - All inputs are ignored.
  - pc holds; transition to RUN.
- RUN, stall = 1: pc, retired and state all hold. Stall overrides every other input, including halt.
- RUN, stall = 0, priority order:
  - halt = 1: state -> HALT, pc holds, halted -> 1, retired += 1.
  - else jump = 1: pc <= {pc_plus4[31:28], jtarget, 2'b00}, retired += 1.
  - else taken: pc <= pc_plus4 + (sign_extend(imm16) << 2), retired += 1.
    - taken = branch & (zero XOR bne).
  - else: pc <= pc_plus4, retired += 1.
- HALT:
  - Absorbing until nreset.
  - All inputs are ignored; pc, retired and halted hold.
- Arithmetic rules:
  - All PC arithmetic is modulo 2^32: pc_plus4 of 32'hFFFF_FFFC is 32'h0000_0000, and branch targets wrap the same way.
  - retired wraps modulo 2^CNT_W.
- pc[1:0] is always 2'b00.
- branch and jump both asserted: jump wins.
- branch with its condition false behaves exactly as sequential.

## Timing
- Reset assertion takes effect immediately, independent of clk; outputs hold reset values while nreset is low.
- Reset asserted mid-operation, including in HALT, returns to BOOT with all reset values.
- First instruction fetch is at RESET_VECTOR:
  - pc stays at RESET_VECTOR through the BOOT edge.
  - First PC change occurs on the second rising edge after nreset rises.
- Next-PC latency is one edge:
  - The branch/jump decision uses inputs sampled at the rising edge.
  - The new pc is visible immediately after that edge.
- halted rises on the same edge that accepts halt. pc after that edge still equals the halt instruction's address.
- pc_plus4 follows pc combinationally with no added register stage.

## Test plan
- Reset then 3 free-running cycles, no control inputs:
  - pc sequence 0x00400020, 0x00400020 (BOOT), 0x00400024, 0x00400028.
  - retired = 2 after the third edge.
- At pc=0x00400030, branch=1, bne=0, zero=1, imm16=16'hFFFC -> next pc = 0x00400024.
  - Repeat with zero=0 -> next pc = 0x00400034.
  - Repeat with bne=1, zero=0, imm16=16'h0003 -> next pc = 0x00400040.
- At pc=0x00400040:
  - jump=1, jtarget=26'h0100008 -> next pc = 0x00400020.
  - jump=1 with branch=1 and the branch condition true -> jump target taken.
- stall=1 for 4 cycles with halt=1 -> pc and retired unchanged, halted=0. Release stall -> halted=1 after one edge, pc unchanged, retired +1. Further jump/branch inputs -> no change.
- Force pc to 0xFFFFFFFC (via branch) -> next sequential pc = 0x00000000.
  - Then assert nreset low between clock edges -> pc = 0x00400020, retired = 0, halted = 0 with no clock edge.
